// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: a 1-bit delay line whose depth (1..MAX_DEPTH enabled edges)
// is set at run time, with a controller that sequences fill, run and flush.
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   en, d           sample strobe and data input
//   cfg_load        one-cycle request to apply cfg_depth
//   cfg_depth       requested delay in enabled edges
//   q, q_valid      delayed data and its validity flag
//   busy            high while flushing or filling
//   cfg_err         one-cycle pulse when a load is rejected
// Optional: define DLY_CTRL_BYPASS_EN to accept depth 0 as a combinational
// bypass (q = d).
module delay_line_ctrl #(
  parameter int unsigned MAX_DEPTH = 16,
  parameter int unsigned DEPTH_W   = 5,
  parameter int unsigned RST_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               d,
  input  logic               cfg_load,
  input  logic [DEPTH_W-1:0] cfg_depth,
  output logic               q,
  output logic               q_valid,
  output logic               busy,
  output logic               cfg_err
);

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] RST_D = DEPTH_W'(RST_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE   = DEPTH_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t               state;
  logic [MAX_DEPTH-1:0] taps;
  logic [DEPTH_W-1:0]   depth;
  logic [DEPTH_W-1:0]   fill_cnt;
  logic [DEPTH_W-1:0]   fill_nxt;
  logic                 cfg_ok;
  logic                 q_tap;

  always_comb begin
`ifdef DLY_CTRL_BYPASS_EN
    cfg_ok = cfg_load && (cfg_depth <= MAX_D);
`else
    cfg_ok = cfg_load && (cfg_depth != '0) && (cfg_depth <= MAX_D);
`endif
    fill_nxt = fill_cnt + ONE;
  end

  // Tap select by comparison rather than taps[depth-1], so an out-of-range
  // depth can never index past the line.
  always_comb begin
    q_tap = 1'b0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (depth == DEPTH_W'(i + 1)) q_tap = taps[i];
    end
  end

`ifdef DLY_CTRL_BYPASS_EN
  assign q = (depth == '0) ? d : q_tap;
`else
  assign q = q_tap;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      taps     <= '0;
      depth    <= RST_D;
      fill_cnt <= '0;
      q_valid  <= 1'b0;
      busy     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        // Accepted load beats en: taps are cleared now so q reads 0 in FLUSH.
        state    <= FLUSH;
        depth    <= cfg_depth;
        taps     <= '0;
        fill_cnt <= '0;
        busy     <= 1'b1;
        q_valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (en) begin
              taps     <= {taps[MAX_DEPTH-2:0], d};
              fill_cnt <= ONE;
              if (depth == ONE) begin
                state   <= RUN;
                q_valid <= 1'b1;
                busy    <= 1'b0;
              end else begin
                state <= FILL;
                busy  <= 1'b1;
              end
            end
          end
          FILL: begin
            if (en) begin
              taps     <= {taps[MAX_DEPTH-2:0], d};
              fill_cnt <= fill_nxt;
              if (fill_nxt >= depth) begin
                state   <= RUN;
                q_valid <= 1'b1;
                busy    <= 1'b0;
              end
            end
          end
          RUN: begin
            if (en) taps <= {taps[MAX_DEPTH-2:0], d};
          end
          FLUSH: begin
            taps     <= '0;
            fill_cnt <= '0;
`ifdef DLY_CTRL_BYPASS_EN
            if (depth == '0) begin
              state   <= RUN;
              q_valid <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state <= FILL;
              busy  <= 1'b1;
            end
`else
            state <= FILL;
            busy  <= 1'b1;
`endif
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            q_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Controller plus shift-register delay line that delays a 1-bit sample stream by a run-time programmable number of enabled clock edges (1..MAX_DEPTH).
- Sequences fill, run and reconfiguration (flush) phases, and flags when the output is valid.
- Generalises the fixed two-stage delay flop so datapath alignment can be retuned without re-synthesis.

Parameters:
- MAX_DEPTH, 16: number of physical taps and the maximum legal programmed depth.
- DEPTH_W, 5: width of cfg_depth; must satisfy 2^DEPTH_W > MAX_DEPTH.
- RST_DEPTH, 2: depth in force after reset; legal range 1..MAX_DEPTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe; the line shifts only on edges where en=1.
- d  in  1  data input.
- cfg_load  in  1  one-cycle request to apply cfg_depth.
- cfg_depth  in  DEPTH_W  requested delay, in enabled edges.
- q  out  1  delayed data, equal to tap[depth-1].
- q_valid  out  1  q holds a genuine sample from the current configuration.
- busy  out  1  controller is in FLUSH or FILL.
- cfg_err  out  1  one-cycle pulse when cfg_load is rejected.

Behaviour:
- Reset (async, rst=1):
  - All taps=0, depth=RST_DEPTH, fill_cnt=0, state=IDLE.
  - q=0, q_valid=0, busy=0, cfg_err=0.
  - Reset mid-operation abandons any fill or flush immediately.
- Datapath:
  - On an enabled edge: tap[0]<=d and tap[i]<=tap[i-1].
  - q is a registered-tap mux selected by the stored depth, so d captured at enabled edge n appears on q after enabled edge n+depth-1.
  - Depth 2 therefore reproduces the legacy two-flop delay.
- fill_cnt:
  - Counts enabled edges since FILL was entered.
  - Saturates at depth.
- FSM states:
  - IDLE: waiting for the first en; q_valid=0, busy=0. en=1 -> FILL, and that edge shifts with fill_cnt=1.
  - FILL: busy=1, q_valid=0. Each en increments fill_cnt. When fill_cnt reaches depth on an edge -> RUN; q_valid=1 from that edge.
  - RUN: busy=0, q_valid=1, shifting on en.
  - FLUSH: lasts exactly one cycle. All taps cleared to 0, fill_cnt=0, busy=1, q_valid=0, no shift even if en=1. Then -> FILL.
- cfg_load handling (any state):
  - Legal cfg_depth (1..MAX_DEPTH): depth<=cfg_depth, -> FLUSH. This applies even when the value equals the current depth.
  - Illegal cfg_depth (0 or >MAX_DEPTH): cfg_err=1 for one cycle. Depth, state and taps are unchanged, and the edge is treated as a normal en/no-en edge.
- Simultaneous events:
  - Legal cfg_load together with en=1: cfg_load wins and that cycle's d is discarded.
  - cfg_load during FLUSH: re-enters FLUSH with the new depth.
  - cfg_load during FILL: restarts the fill.
- en=0 in any state: taps, fill_cnt and q hold; the state holds, except FLUSH always exits to FILL.
- q is 0 throughout FLUSH and from FILL entry until the taps are written.

Optional Feature:
- Macro: DLY_CTRL_BYPASS_EN.
- Defined:
  - cfg_depth=0 is legal and selects bypass: q=d combinationally.
  - An accepted depth-0 load goes through a one-cycle FLUSH, then directly to RUN with q_valid=1. FILL is skipped.
  - Taps keep shifting but are unused.
  - RST_DEPTH stays restricted to 1..MAX_DEPTH.
- Not defined: cfg_depth=0 is rejected with cfg_err, and no bypass mux exists.

Test Plan:
- Reset response: assert rst asynchronously mid-cycle -> q=0, q_valid=0, busy=0 and cfg_err=0 immediately. After release, state IDLE and depth=2.
- Default latency: after reset, en=1 continuously, d=1,0,1,1,0 -> q_valid rises after the 2nd edge. q shows d delayed by one edge: 1,0,1,1.
- Reconfigure: in RUN at depth 2, pulse cfg_load with cfg_depth=5 -> busy=1 and q_valid=0 for 1 FLUSH cycle plus 5 enabled edges. q=0 during FLUSH; q_valid then returns with 5-edge delay.
- Rejection: cfg_load with cfg_depth=17 (and separately 0, macro off) -> cfg_err high for exactly 1 cycle. Depth, q_valid and the q stream are undisturbed.
- Collision and gaps: cfg_load(depth=3) on the same edge as en=1, d=1 -> that d never appears on q. Then en toggling 1,0,1,0,1 -> q_valid rises on the 3rd enabled edge, not the 3rd clock.
- Reset mid-fill: depth 8, rst asserted after 4 enabled edges -> all outputs 0 and depth=2. A subsequent fill needs 2 enabled edges.
